sipo_deserializer: RTL
======================

Name: sipo_deserializer

Overview:
- Serial-in/parallel-out receiver: the receive end of the board's serial shift link.
- Samples one bit per qualified bit strobe, assembles WIDTH-bit words and presents each word on a registered parallel output with a valid/ready handshake.
- Sits after the clock-divider strobe and feeds switch/LED display logic or any downstream consumer.

Parameters:
- WIDTH, 8: bits per word; legal range 2..32.
- MSB_FIRST, 1: 1 = first received bit lands in par_data[WIDTH-1]; 0 = first received bit lands in par_data[0].

Ports:
- clk, in, 1: system clock; all logic on the rising edge.
- rst, in, 1: reset, synchronous, active-high.
- bit_tick, in, 1: one-cycle bit strobe, e.g. from the clock divider.
- ser_en, in, 1: serial-line qualifier; a bit is accepted only when bit_tick && ser_en.
- ser_in, in, 1: serial data bit.
- abort, in, 1: synchronous discard of the partially assembled word.
- par_data, out, WIDTH: assembled word; held stable while par_valid=1.
- par_valid, out, 1: par_data holds an unconsumed word.
- par_ready, in, 1: consumer accepts the word; transfer occurs when par_valid && par_ready.
- busy, out, 1: 1 while a partial word is in progress (bit_count != 0).
- bit_count, out, CW: bits captured in the current word; CW = ceil(log2(WIDTH+1)).
- overrun, out, 1: sticky; a completed word was dropped.
- clr_ovr, in, 1: synchronous clear of overrun.

Behaviour:
- Reset (rst=1 at an edge): shift register=0, bit_count=0, par_data=0, par_valid=0, overrun=0, busy=0. Reset overrides every other input, and a reset mid-word discards the partial word.
- States: IDLE (bit_count=0) and SHIFT (1..WIDTH-1 bits held). The transition from IDLE to SHIFT occurs on the first accepted bit.
- Accepted bit ("acc" = bit_tick && ser_en && !abort):
  - MSB_FIRST=1: shift left, ser_in enters bit 0.
  - MSB_FIRST=0: shift right, ser_in enters bit WIDTH-1.
  - bit_count increments.
- Word completion occurs on the acc that captures the WIDTH-th bit:
  - Word = shift contents including the current bit. bit_count returns to 0, the block returns to IDLE, and the shift register clears.
  - If par_valid=0, or par_valid && par_ready in the same cycle: par_data <= word and par_valid=1 from the next cycle. Latency is 1 clk from the capture edge.
  - Otherwise the word is dropped, par_data and par_valid are unchanged, and overrun <= 1.
- Handshake:
  - A transfer (par_valid && par_ready) without a simultaneous completion clears par_valid at the next edge; par_data holds its last value.
  - A transfer together with a completion reloads par_data and leaves par_valid at 1, with no overrun.
  - par_ready is ignored while par_valid=0.
- abort:
  - Clears the shift register and bit_count at the next edge.
  - Has priority over a simultaneous acc; that bit is discarded and no completion occurs.
  - Does not affect par_data, par_valid or overrun.
- bit_tick with ser_en=0: no state change.
- bit_tick is never assumed to be a single pulse; every cycle it is high counts as a separate strobe.
- overrun:
  - Set by a dropped word; cleared by clr_ovr or rst.
  - A set and a clr_ovr in the same cycle leave the flag set (set wins).
- busy = (bit_count != 0), registered-equivalent with no combinational path from inputs.
- Outputs are driven from registers only; no combinational path exists from inputs to outputs.

Test Plan:
- WIDTH=8, MSB_FIRST=1: reset, then 8 accepted bits 1,0,1,1,0,0,1,0 with par_ready=0 -> par_valid rises 1 clk after the 8th strobe with par_data=8'hB2; bit_count steps 1..7 then 0; busy=1 during bits 1-7; overrun=0.
- MSB_FIRST=0, same bit sequence -> par_data=8'h4D.
- Leave the word 8'hB2 unconsumed, then shift a second word 8'hFF -> par_data stays 8'hB2, overrun=1. Pulse clr_ovr -> overrun=0.
- par_ready=1 on the same cycle as the 8th bit of 8'h3C while 8'hB2 is valid -> par_data becomes 8'h3C, par_valid stays 1, overrun=0.
- After 5 accepted bits, assert abort together with a bit_tick -> bit_count=0 and busy=0. The next 8 bits 0x5A produce par_data=8'h5A (no leftover bits).
- After 3 bits, assert rst -> all outputs 0. Toggling bit_tick with ser_en=0 -> bit_count stays 0.

Source files
------------

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: serial-in/parallel-out receiver for the board's shift link.
// Collects one bit on each qualified strobe (bit_tick && ser_en), builds a
// WIDTH-bit word and offers it downstream on a registered valid/ready port.
// A finished word that finds the output still occupied is dropped, and the
// sticky overrun flag records the loss.
module sipo_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_tick,
  input  logic             ser_en,
  input  logic             ser_in,
  input  logic             abort,
  output logic [WIDTH-1:0] par_data,
  output logic             par_valid,
  input  logic             par_ready,
  output logic             busy,
  output logic [CW-1:0]    bit_count,
  output logic             overrun,
  input  logic             clr_ovr
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    bit_count_q, bit_count_d;
  logic [WIDTH-1:0] par_data_q, par_data_d;
  logic             par_valid_q, par_valid_d;
  logic             overrun_q, overrun_d;

  logic             acc;
  logic             last_bit;
  logic             word_take;
  logic             xfer;
  logic [WIDTH-1:0] shifted;

  // Next-state logic: abort beats a simultaneous bit, and a completed word
  // either loads the output register or is dropped with overrun set.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_count_d = bit_count_q;
    par_data_d  = par_data_q;
    par_valid_d = par_valid_q;
    overrun_d   = overrun_q;

    acc       = bit_tick && ser_en && !abort;
    last_bit  = acc && (bit_count_q == CW'(WIDTH - 1));
    xfer      = par_valid_q && par_ready;
    word_take = last_bit && (!par_valid_q || par_ready);

    if (MSB_FIRST) begin
      shifted = {shift_q[WIDTH-2:0], ser_in};
    end else begin
      shifted = {ser_in, shift_q[WIDTH-1:1]};
    end

    if (abort) begin
      shift_d     = '0;
      bit_count_d = '0;
    end else if (acc) begin
      if (last_bit) begin
        shift_d     = '0;
        bit_count_d = '0;
      end else begin
        shift_d     = shifted;
        bit_count_d = bit_count_q + CW'(1);
      end
    end

    state_d = (bit_count_d != '0) ? SHIFT : IDLE;

    if (word_take) begin
      par_data_d  = shifted;
      par_valid_d = 1'b1;
    end else if (xfer) begin
      par_valid_d = 1'b0;
    end

    if (last_bit && !word_take) begin
      overrun_d = 1'b1;
    end else if (clr_ovr) begin
      overrun_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_count_q <= '0;
      par_data_q  <= '0;
      par_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_count_q <= bit_count_d;
      par_data_q  <= par_data_d;
      par_valid_q <= par_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign par_data  = par_data_q;
  assign par_valid = par_valid_q;
  assign bit_count = bit_count_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q == SHIFT);

endmodule
